// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC and keeps at most one instruction-memory read in flight.
// Holds the returned instruction until it is acked; a misaligned next PC traps into a sticky FAULT state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        jump,
  input  logic        pcsrc,
  input  logic [31:0] pcbranch,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired,
  output logic        fault
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        fault_q, fault_d;
  logic [31:0] pcplus4_w;
  logic [31:0] next_pc;

  assign pcplus4_w = pc_q + 32'd4;

  // Jump outranks a taken branch; both are only meaningful on the acking cycle.
  assign next_pc = jump  ? {pcplus4_w[31:28], instr_q[25:0], 2'b00} :
                   pcsrc ? pcbranch : pcplus4_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          retired_d = retired_q + 32'd1;
          pc_d      = next_pc;
          if (next_pc[1:0] == 2'b00) begin
            state_d = S_FETCH;
          end else begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  // Request is gated by reset so it reads 0 while reset is held.
  always_comb begin
    imem_req    = (state_q == S_FETCH) && !reset;
    instr_valid = (state_q == S_HOLD);
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign pc        = pc_q;
  assign pcplus4   = pcplus4_w;
  assign retired   = retired_q;
  assign fault     = fault_q;

endmodule
